// File: rtl/muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | muldiv_unit: iterative MULT/MULTU/DIV/DIVU with architectural HI/LO regs.   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             dbz_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int         CW       = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic               is_div_q, zero_q, neg_res_q, neg_rem_q;
  logic [2*WIDTH-1:0] mcand_q;   // multiplicand (shifted left) or divisor in low half
  logic [WIDTH-1:0]   shreg_q;   // multiplier (shifted right) or dividend/quotient
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH:0]     rem_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               dbz_q, done_q;

  logic               accept_d, finish_d, idle_d;
  logic               b_zero_d, a_neg_d, b_neg_d;
  logic [WIDTH-1:0]   a_mag_d, b_mag_d;
  logic [WIDTH+1:0]   trial_d, diff_d;
  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH-1:0]   quo_d, rem_res_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_i) state_d = (op_i[1] && b_zero_d) ? S_FINISH : S_RUN;
      S_RUN:    if (cnt_q == C_LAST) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    idle_d   = (state_q == S_IDLE);
    finish_d = (state_q == S_FINISH);
    accept_d = idle_d && start_i;
    busy_o   = !idle_d;
  end

  assign b_zero_d = (b_i == '0);
  assign a_neg_d  = !op_i[0] && a_i[WIDTH-1];
  assign b_neg_d  = !op_i[0] && b_i[WIDTH-1];
  assign a_mag_d  = a_neg_d ? -a_i : a_i;
  assign b_mag_d  = b_neg_d ? -b_i : b_i;

  // Restoring step; the extra top bit of the difference is the borrow
  assign trial_d  = {rem_q, shreg_q[WIDTH-1]};
  assign diff_d   = trial_d - {2'b00, mcand_q[WIDTH-1:0]};

  assign prod_d    = neg_res_q ? -acc_q : acc_q;
  assign quo_d     = neg_res_q ? -shreg_q : shreg_q;
  assign rem_res_d = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      zero_q    <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      mcand_q   <= '0;
      shreg_q   <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= finish_d;
      if (accept_d) begin
        cnt_q    <= '0;
        is_div_q <= op_i[1];
        zero_q   <= op_i[1] && b_zero_d;
        dbz_q    <= 1'b0;
        acc_q    <= '0;
        // Divide-by-zero preloads the result registers so FINISH needs no special case
        if (op_i[1] && b_zero_d) begin
          neg_res_q <= 1'b0;
          neg_rem_q <= 1'b0;
          shreg_q   <= '1;
          rem_q     <= {1'b0, a_i};
          mcand_q   <= '0;
        end else begin
          neg_res_q <= a_neg_d ^ b_neg_d;
          neg_rem_q <= a_neg_d;
          rem_q     <= '0;
          mcand_q   <= {{WIDTH{1'b0}}, op_i[1] ? b_mag_d : a_mag_d};
          shreg_q   <= op_i[1] ? a_mag_d : b_mag_d;
        end
      end else if (idle_d) begin
        if (hi_we_i) hi_q <= wdata_i;
        if (lo_we_i) lo_q <= wdata_i;
      end else if (state_q == S_RUN) begin
        cnt_q <= cnt_q + CW'(1);
        if (is_div_q) begin
          rem_q   <= diff_d[WIDTH+1] ? trial_d[WIDTH:0] : diff_d[WIDTH:0];
          shreg_q <= {shreg_q[WIDTH-2:0], !diff_d[WIDTH+1]};
        end else begin
          if (shreg_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q <= {mcand_q[2*WIDTH-2:0], 1'b0};
          shreg_q <= {1'b0, shreg_q[WIDTH-1:1]};
        end
      end else if (finish_d) begin
        dbz_q <= zero_q;
        if (is_div_q) begin
          hi_q <= rem_res_d;
          lo_q <= quo_d;
        end else begin
          hi_q <= prod_d[2*WIDTH-1:WIDTH];
          lo_q <= prod_d[WIDTH-1:0];
        end
      end
    end
  end

  assign done_o = done_q;
  assign dbz_o  = dbz_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_muldiv_unit: directed + random checks of muldiv_unit against arithmetic.|
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op_s;
  logic [31:0] a_s, b_s, wdata;
  logic        hi_we, lo_we;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .op_i(op_s), .a_i(a_s), .b_i(b_s),
    .hi_we_i(hi_we), .lo_we_i(lo_we), .wdata_i(wdata),
    .busy_o(busy), .done_o(done), .dbz_o(dbz), .hi_o(hi), .lo_o(lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV signed / and % truncate toward zero
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] ehi, output logic [31:0] elo, output logic edbz);
    longint          sp, sq, sr;
    longint unsigned up;
    edbz = 1'b0;
    case (op)
      2'b00: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        ehi = sp[63:32]; elo = sp[31:0];
      end
      2'b01: begin
        up = {32'h0, a} * {32'h0, b};
        ehi = up[63:32]; elo = up[31:0];
      end
      default: begin
        if (b == 32'h0) begin
          ehi = a; elo = 32'hFFFF_FFFF; edbz = 1'b1;
        end else if (op == 2'b10) begin
          sq = longint'($signed(a)) / longint'($signed(b));
          sr = longint'($signed(a)) % longint'($signed(b));
          ehi = sr[31:0]; elo = sq[31:0];
        end else begin
          ehi = a % b; elo = a / b;
        end
      end
    endcase
  endtask

  // Presents start at a negedge; returns at the negedge where done is high (or bound expires)
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] ehi, elo;
    logic        edbz;
    int          cyc, bcyc, elat;
    model(op, a, b, ehi, elo, edbz);
    elat = (op[1] && b == 32'h0) ? 1 : 33;
    start = 1'b1; op_s = op; a_s = a; b_s = b;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    a_s = $urandom; b_s = $urandom; op_s = 2'($urandom_range(0, 3));
    chk({tag, "/dbz_clr"}, dbz, 1'b0);
    cyc = 0;
    bcyc = busy ? 1 : 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (busy) bcyc++;
    end
    chk({tag, "/lat"}, cyc, elat);
    chk({tag, "/busy"}, bcyc, elat);
    chk({tag, "/hi"}, hi, ehi);
    chk({tag, "/lo"}, lo, elo);
    chk({tag, "/dbz"}, dbz, edbz);
  endtask

  logic [31:0] ehi_t, elo_t, hi_prev, lo_prev;
  logic        edbz_t;
  int          cyc_t;

  initial begin
    rst_n = 1'b0; start = 1'b0; op_s = 2'b00; a_s = '0; b_s = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst/busy", busy, 1'b0);
    chk("rst/done", done, 1'b0);
    chk("rst/dbz", dbz, 1'b0);
    chk("rst/hi", hi, 32'h0);
    chk("rst/lo", lo, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max/hi_k", hi, 32'hFFFF_FFFE);
    chk("multu_max/lo_k", lo, 32'h0000_0001);
    @(negedge clk);
    chk("done_pulse", done, 1'b0);
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7);
    chk("mult_neg/lo_k", lo, 32'hFFFF_FFEB);
    run_op("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000);
    chk("mult_min/hi_k", hi, 32'h4000_0000);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2);
    chk("div_neg/lo_k", lo, 32'hFFFF_FFFD);
    run_op("divu_7_2", 2'b11, 32'd7, 32'd2);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf/lo_k", lo, 32'h8000_0000);

    // Divide by zero then back-to-back start in the done cycle
    run_op("dbz", 2'b10, 32'h0000_1234, 32'h0);
    chk("dbz/hi_k", hi, 32'h0000_1234);
    run_op("after_dbz", 2'b01, 32'd2, 32'd3);
    chk("after_dbz/lo_k", lo, 32'd6);

    // MTLO in idle
    @(negedge clk);
    hi_prev = hi;
    lo_we = 1'b1; wdata = 32'h55;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo/lo", lo, 32'h55);
    chk("mtlo/hi", hi, hi_prev);

    // Start beats a simultaneous MTHI
    hi_we = 1'b1; wdata = 32'hAA;
    run_op("start_wins", 2'b11, 32'd1000, 32'd9);

    // Second start and MTHI mid-RUN are ignored; HI/LO hold during RUN
    @(negedge clk);
    hi_prev = hi; lo_prev = lo;
    model(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, ehi_t, elo_t, edbz_t);
    start = 1'b1; op_s = 2'b01; a_s = 32'h1234_5678; b_s = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; op_s = 2'b10; a_s = 32'd7; b_s = 32'd3; hi_we = 1'b1; wdata = 32'hAA;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    chk("hs/busy", busy, 1'b1);
    chk("hs/hi_hold", hi, hi_prev);
    chk("hs/lo_hold", lo, lo_prev);
    cyc_t = 6;
    while (!done && cyc_t < 100) begin
      @(negedge clk);
      cyc_t++;
    end
    chk("hs/lat", cyc_t, 33);
    chk("hs/hi", hi, ehi_t);
    chk("hs/lo", lo, elo_t);

    // Asynchronous reset during RUN iteration 10
    @(negedge clk);
    start = 1'b1; op_s = 2'b01; a_s = 32'hDEAD_BEEF; b_s = 32'h0000_1357;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst/busy", busy, 1'b0);
    chk("arst/done", done, 1'b0);
    chk("arst/dbz", dbz, 1'b0);
    chk("arst/hi", hi, 32'h0);
    chk("arst/lo", lo, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("post_rst", 2'b11, 32'd100, 32'd7);
    chk("post_rst/lo_k", lo, 32'd14);
    chk("post_rst/hi_k", hi, 32'd2);

    // Randomized operations, with corner operands mixed in
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'h8000_0000;
        default: rb = $urandom;
      endcase
      ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      run_op("rand", 2'($urandom_range(0, 3)), ra, rb);
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
